// File: rtl/plru_state_ctrl_if.sv
// ----------------------------------------------------------------------------
// plru_state_ctrl_if
//   Bundles the access, victim-query and flush signals of the PLRU state
//   controller. The cache controller uses the master modport. The PLRU block
//   uses the slave modport.
//
//   flush_i     : request to clear all PLRU state
//   busy_o      : high while the clear sweep runs
//   acc_valid_i : access (hit or refill) touch strobe
//   acc_set_i   : set index of the access
//   acc_way_i   : one-hot way touched
//   vic_req_i   : victim query request
//   vic_set_i   : set index of the query
//   vic_ready_o : query accepted when high (equals ~busy_o)
//   vic_valid_o : victim result valid, one-cycle pulse
//   vic_way_o   : one-hot victim way, registered
//
//   NUM_WAY and NUM_SET must match the parameters of the attached
//   plru_state_ctrl instance.
// ----------------------------------------------------------------------------
interface plru_state_ctrl_if #(
  parameter int NUM_WAY = 4,
  parameter int NUM_SET = 64
);
  localparam int SW = $clog2(NUM_SET);

  logic               flush_i;
  logic               busy_o;
  logic               acc_valid_i;
  logic [SW-1:0]      acc_set_i;
  logic [NUM_WAY-1:0] acc_way_i;
  logic               vic_req_i;
  logic [SW-1:0]      vic_set_i;
  logic               vic_ready_o;
  logic               vic_valid_o;
  logic [NUM_WAY-1:0] vic_way_o;

  modport master (
    output flush_i, acc_valid_i, acc_set_i, acc_way_i, vic_req_i, vic_set_i,
    input  busy_o, vic_ready_o, vic_valid_o, vic_way_o
  );

  modport slave (
    input  flush_i, acc_valid_i, acc_set_i, acc_way_i, vic_req_i, vic_set_i,
    output busy_o, vic_ready_o, vic_valid_o, vic_way_o
  );
endinterface

// File: rtl/plru_state_ctrl.sv
// ----------------------------------------------------------------------------
// plru_state_ctrl
//   Tree pseudo-LRU replacement state for a set-associative cache.
//   The block keeps NUM_WAY-1 tree bits per set. An access marks its way as
//   recently used by pointing every node on the way's path away from that
//   way. A victim query follows the node bits from the root to a leaf. The
//   tree array has no reset so it can map to RAM. After reset or a flush, a
//   sweep of NUM_SET cycles writes zero to every set.
//
//   clk_i  : single clock, rising edge
//   rst_ni : synchronous active-low reset
//   bus    : plru_state_ctrl_if.slave (access, victim query, flush and busy)
// ----------------------------------------------------------------------------
module plru_state_ctrl #(
  parameter int NUM_WAY = 4,
  parameter int NUM_SET = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  plru_state_ctrl_if.slave  bus
);
  localparam int SW = $clog2(NUM_SET);
  localparam int LW = $clog2(NUM_WAY);
  localparam logic [SW-1:0] LAST_SET = SW'(NUM_SET - 1);

  typedef logic [NUM_WAY-2:0] tree_t;
  typedef enum logic {SWEEP, IDLE} state_t;

  state_t             state_q;
  logic [SW-1:0]      cnt_q;
  logic               busy_q;
  logic               vic_valid_q;
  logic [NUM_WAY-1:0] vic_way_q;
  tree_t              tree_q [NUM_SET];

  logic acc_fire;
  logic vic_fire;

  // Accesses and queries are ignored while the sweep owns the array.
  assign acc_fire = bus.acc_valid_i & ~busy_q;
  assign vic_fire = bus.vic_req_i & ~busy_q;

  assign bus.busy_o      = busy_q;
  assign bus.vic_ready_o = ~busy_q;
  assign bus.vic_valid_o = vic_valid_q;
  assign bus.vic_way_o   = vic_way_q;

  // Each hot way, in ascending order, points every node on its path away
  // from itself. A later (higher) way therefore wins on shared nodes.
  // Node for level l on way w's path is (2^l - 1) + (w >> (LW - l)).
  // The address bit of w at level l is bit LW-1-l, so level 0 uses the MSB.
  function automatic tree_t touch(input tree_t cur, input logic [NUM_WAY-1:0] way);
    tree_t nxt;
    // NOTE: start from the current value so every bit has a defined
    // assignment on every path; a partial assignment here would infer a
    // latch wherever this function is evaluated combinationally.
    nxt = cur;
    for (int w = 0; w < NUM_WAY; w++) begin
      if (way[w]) begin
        for (int l = 0; l < LW; l++) begin
          nxt[(2 ** l) - 1 + (w >> (LW - l))] = ~w[LW-1-l];
        end
      end
    end
    return nxt;
  endfunction

  // Walk from the root toward the leaf. A node bit of 0 selects the lower
  // subtree and a node bit of 1 selects the upper subtree. The children of
  // node n are 2n+1 (lower) and 2n+2 (upper).
  function automatic logic [NUM_WAY-1:0] victim(input tree_t cur);
    logic [NUM_WAY-1:0] onehot;
    int node;
    int way;
    onehot = '0;
    node   = 0;
    way    = 0;
    for (int l = 0; l < LW; l++) begin
      way  = way * 2 + int'(cur[node]);
      node = node * 2 + 1 + int'(cur[node]);
    end
    onehot[way] = 1'b1;
    return onehot;
  endfunction

  // Control FSM and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values. In particular, a same-cycle victim
  // read sees tree_q from before the access commits.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= SWEEP;
      cnt_q       <= '0;
      busy_q      <= 1'b1;
      vic_valid_q <= 1'b0;
      vic_way_q   <= '0;
    end else begin
      vic_valid_q <= vic_fire;
      if (vic_fire) begin
        vic_way_q <= victim(tree_q[bus.vic_set_i]);
      end

      case (state_q)
        SWEEP: begin
          if (bus.flush_i) begin
            cnt_q <= '0;
          end else if (cnt_q == LAST_SET) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + SW'(1);
          end
        end
        IDLE: begin
          if (bus.flush_i) begin
            state_q <= SWEEP;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= SWEEP;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Tree array. The sweep is the only way the array is cleared.
  // NOTE: this array has no reset on purpose. Resetting it would block
  // mapping to RAM. The sweep after reset provides the clear.
  always_ff @(posedge clk_i) begin
    if (state_q == SWEEP) begin
      tree_q[cnt_q] <= '0;
    end else if (acc_fire) begin
      tree_q[bus.acc_set_i] <= touch(tree_q[bus.acc_set_i], bus.acc_way_i);
    end
  end
endmodule

// File: tb/tb_plru_state_ctrl.sv
// ----------------------------------------------------------------------------
// tb_plru_state_ctrl
//   Self-checking bench for plru_state_ctrl with NUM_WAY=4 and NUM_SET=64.
//   The reference model does not store tree bits. For each tree node it
//   records which way touched that node most recently. The victim walk at
//   each node steers away from that most recent toucher, and goes to the
//   lower side if the node has never been touched. The model also tracks
//   busy time as a countdown of remaining sweep cycles.
// ----------------------------------------------------------------------------
module tb_plru_state_ctrl;
  localparam int NUM_WAY = 4;
  localparam int NUM_SET = 64;
  localparam int LW      = 2;

  logic clk_i;
  logic rst_ni;

  plru_state_ctrl_if #(.NUM_WAY(NUM_WAY), .NUM_SET(NUM_SET)) bus ();

  plru_state_ctrl #(.NUM_WAY(NUM_WAY), .NUM_SET(NUM_SET)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: last[s][lvl][prefix] holds the way that most recently
  // touched that node, or -1 if the node has never been touched.
  int         last_touch [NUM_SET][LW][2];
  logic       m_busy;
  int         m_left;
  logic [3:0] m_way;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int s = 0; s < NUM_SET; s++)
      for (int l = 0; l < LW; l++)
        for (int p = 0; p < 2; p++) last_touch[s][l][p] = -1;
  endfunction

  function automatic void model_touch(input int s, input logic [3:0] way);
    for (int w = 0; w < NUM_WAY; w++)
      if (way[w])
        for (int l = 0; l < LW; l++) last_touch[s][l][w >> (LW - l)] = w;
  endfunction

  function automatic logic [3:0] model_victim(input int s);
    int prefix = 0;
    for (int l = 0; l < LW; l++) begin
      int t   = last_touch[s][l][prefix];
      int dir = 0;
      if (t >= 0) dir = ((t >> (LW - 1 - l)) & 1) == 1 ? 0 : 1;
      prefix = prefix * 2 + dir;
    end
    return 4'(1 << prefix);
  endfunction

  // Runs one clock cycle with the given inputs and checks the outputs
  // against the model.
  task automatic do_cycle(input logic av, input int as, input logic [3:0] aw,
                          input logic vq, input int vs, input logic fl);
    logic       accept;
    logic [3:0] exp_way;
    check("ready", {31'd0, bus.vic_ready_o}, {31'd0, ~m_busy});
    accept  = vq & ~m_busy;
    exp_way = accept ? model_victim(vs) : m_way;
    bus.acc_valid_i = av;
    bus.acc_set_i   = 6'(as);
    bus.acc_way_i   = aw;
    bus.vic_req_i   = vq;
    bus.vic_set_i   = 6'(vs);
    bus.flush_i     = fl;
    @(posedge clk_i);
    #1;
    if (!m_busy) begin
      if (av) model_touch(as, aw);
      if (fl) begin
        m_busy = 1'b1;
        m_left = NUM_SET;
        model_clear();
      end
    end else if (fl) begin
      m_left = NUM_SET;
    end else begin
      m_left--;
      if (m_left == 0) m_busy = 1'b0;
    end
    m_way = exp_way;
    check("busy", {31'd0, bus.busy_o}, {31'd0, m_busy});
    check("vic_valid", {31'd0, bus.vic_valid_o}, {31'd0, accept});
    check("vic_way", {28'd0, bus.vic_way_o}, {28'd0, exp_way});
  endtask

  task automatic idle_cycle();
    do_cycle(1'b0, 0, 4'b0000, 1'b0, 0, 1'b0);
  endtask

  // Applies one reset edge, optionally with a query pending in the same cycle.
  task automatic apply_reset(input logic with_query);
    rst_ni          = 1'b0;
    bus.vic_req_i   = with_query;
    bus.vic_set_i   = '0;
    bus.acc_valid_i = 1'b0;
    bus.acc_way_i   = '0;
    bus.acc_set_i   = '0;
    bus.flush_i     = 1'b0;
    @(posedge clk_i);
    #1;
    m_busy = 1'b1;
    m_left = NUM_SET;
    m_way  = '0;
    model_clear();
    check("rst_busy", {31'd0, bus.busy_o}, 32'd1);
    check("rst_ready", {31'd0, bus.vic_ready_o}, 32'd0);
    check("rst_valid", {31'd0, bus.vic_valid_o}, 32'd0);
    check("rst_way", {28'd0, bus.vic_way_o}, 32'd0);
    rst_ni        = 1'b1;
    bus.vic_req_i = 1'b0;
  endtask

  // Counts cycles until busy_o falls, bounded by a cycle budget.
  task automatic measure_busy(input string tag, input int exp_len);
    int c = 0;
    while (bus.busy_o && c < 200) begin
      idle_cycle();
      c++;
    end
    check(tag, 32'(c), 32'(exp_len));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_ni          = 1'b0;
    bus.flush_i     = 1'b0;
    bus.acc_valid_i = 1'b0;
    bus.acc_set_i   = '0;
    bus.acc_way_i   = '0;
    bus.vic_req_i   = 1'b0;
    bus.vic_set_i   = '0;
    @(posedge clk_i);
    #1;
    apply_reset(1'b0);
    measure_busy("busy_after_reset", 64);

    // Fresh set 5 gives victim 0001.
    do_cycle(1'b0, 0, 4'b0000, 1'b1, 5, 1'b0);
    check("fresh_set5", {28'd0, bus.vic_way_o}, 32'b0001);

    // Touch sequence on set 5. Set 6 must not change.
    do_cycle(1'b1, 5, 4'b0001, 1'b0, 0, 1'b0);
    do_cycle(1'b0, 0, 4'b0000, 1'b1, 5, 1'b0);
    check("set5_after_w0", {28'd0, bus.vic_way_o}, 32'b0100);
    do_cycle(1'b1, 5, 4'b0100, 1'b0, 0, 1'b0);
    do_cycle(1'b0, 0, 4'b0000, 1'b1, 5, 1'b0);
    check("set5_after_w2", {28'd0, bus.vic_way_o}, 32'b0010);
    do_cycle(1'b0, 0, 4'b0000, 1'b1, 6, 1'b0);
    check("set6_untouched", {28'd0, bus.vic_way_o}, 32'b0001);

    // A touch and a query on set 3 in the same cycle: the query sees the old state.
    do_cycle(1'b1, 3, 4'b0001, 1'b1, 3, 1'b0);
    check("same_cycle", {28'd0, bus.vic_way_o}, 32'b0001);
    do_cycle(1'b0, 0, 4'b0000, 1'b1, 3, 1'b0);
    check("next_cycle", {28'd0, bus.vic_way_o}, 32'b0100);

    // Multi-hot touch, then a zero touch that must change nothing.
    do_cycle(1'b1, 9, 4'b0011, 1'b0, 0, 1'b0);
    do_cycle(1'b0, 0, 4'b0000, 1'b1, 9, 1'b0);
    check("multihot", {28'd0, bus.vic_way_o}, 32'b0100);
    do_cycle(1'b1, 9, 4'b0000, 1'b0, 0, 1'b0);
    do_cycle(1'b0, 0, 4'b0000, 1'b1, 9, 1'b0);
    check("zero_touch", {28'd0, bus.vic_way_o}, 32'b0100);

    // Random traffic on a few sets, so that sets collide often.
    for (int i = 0; i < 2000; i++) begin
      do_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 7), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 199) == 0));
    end
    while (m_busy) idle_cycle();

    // Flush in the middle of traffic. Traffic during the sweep is ignored,
    // then every set reads back 0001 with back-to-back queries.
    for (int i = 0; i < 20; i++)
      do_cycle(1'b1, $urandom_range(0, 63), 4'($urandom_range(1, 15)), 1'b0, 0, 1'b0);
    do_cycle(1'b1, 1, 4'b0001, 1'b1, 1, 1'b1);
    for (int i = 0; i < NUM_SET; i++)
      do_cycle(1'b1, $urandom_range(0, 63), 4'($urandom_range(1, 15)),
               1'b1, $urandom_range(0, 63), 1'b0);
    check("flush_done", {31'd0, bus.busy_o}, 32'd0);
    for (int s = 0; s < NUM_SET; s++) begin
      do_cycle(1'b0, 0, 4'b0000, 1'b1, s, 1'b0);
      check("post_flush", {28'd0, bus.vic_way_o}, 32'b0001);
    end

    // A flush at sweep cycle 30 restarts the full sweep length.
    do_cycle(1'b0, 0, 4'b0000, 1'b0, 0, 1'b1);
    for (int i = 0; i < 30; i++) idle_cycle();
    do_cycle(1'b0, 0, 4'b0000, 1'b0, 0, 1'b1);
    measure_busy("flush_restart", 64);

    // Reset in the middle of a sweep restarts the sweep.
    do_cycle(1'b0, 0, 4'b0000, 1'b0, 0, 1'b1);
    for (int i = 0; i < 20; i++) idle_cycle();
    apply_reset(1'b0);
    measure_busy("reset_mid_sweep", 64);

    // Reset together with a query: no victim result.
    do_cycle(1'b1, 2, 4'b1000, 1'b0, 0, 1'b0);
    apply_reset(1'b1);
    measure_busy("reset_mid_query", 64);
    do_cycle(1'b0, 0, 4'b0000, 1'b1, 2, 1'b0);
    check("after_reset_set2", {28'd0, bus.vic_way_o}, 32'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/plru_state_ctrl.md
PLRU_STATE_CTRL -- requirements
Module: plru_state_ctrl

Interface
REQ-001 SHALL have parameter NUM_WAY, default 4, meaning ways per set; a power of two, at least 2.
REQ-002 SHALL have parameter NUM_SET, default 64, meaning sets tracked; a power of two, at least 2 (SW = $clog2(NUM_SET)).
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port flush_i  input  1  request to clear all PLRU state.
REQ-006 SHALL have port busy_o  output  1  high while the clear sweep runs.
REQ-007 SHALL have port acc_valid_i  input  1  access (hit or refill) touch strobe.
REQ-008 SHALL have port acc_set_i  input  SW  set index of the access.
REQ-009 SHALL have port acc_way_i  input  NUM_WAY  one-hot way touched.
REQ-010 SHALL have port vic_req_i  input  1  victim query request.
REQ-011 SHALL have port vic_set_i  input  SW  set index of the query.
REQ-012 SHALL have port vic_ready_o  output  1  query accepted when high; equals ~busy_o.
REQ-013 SHALL have port vic_valid_o  output  1  victim result valid, one-cycle pulse.
REQ-014 SHALL have port vic_way_o  output  NUM_WAY  one-hot victim way, registered.

Function
REQ-015 SHALL store NUM_WAY-1 tree bits per set. Node index for level L and way w = (2^L - 1) + (w >> (log2(NUM_WAY) - L)).
REQ-016 Node bit encoding SHALL be: 0 means the victim lies in the lower-index subtree, 1 means the higher-index subtree.
REQ-017 Touch update SHALL work as follows: on acc_valid_i high while not busy, for each hot way w in ascending index order, each node on w's path SHALL be set to the inverse of w's address bit at that level. The combined result SHALL be written to acc_set_i at the clock edge.
REQ-018 acc_way_i equal to zero SHALL leave state unchanged. With multi-hot, the highest-index way SHALL win on shared nodes.
REQ-019 Victim selection SHALL pick the unique way w whose address bit equals the node bit at every level of its path.
REQ-020 Victim latency SHALL be as follows: a query accepted in cycle N (vic_req_i and vic_ready_o) gives vic_valid_o=1 and vic_way_o in cycle N+1.
REQ-021 When no query was accepted in the prior cycle, vic_valid_o SHALL be 0 and vic_way_o SHALL hold its last value.
REQ-022 Read ordering SHALL be as follows: the victim SHALL reflect state including every update committed at or before edge N. An access in the same cycle N to the same set SHALL NOT affect that victim. Its update SHALL be visible to queries from cycle N+1.
REQ-023 A victim query SHALL NOT modify state; the user issues an access to mark the refilled way.
REQ-024 The FSM SHALL have states SWEEP and IDLE, with a set counter cnt of SW bits.
REQ-025 In SWEEP, each cycle SHALL write all-zero to set cnt and increment cnt. After writing set NUM_SET-1, the FSM SHALL go to IDLE. The sweep lasts exactly NUM_SET cycles.
REQ-026 In SWEEP, busy_o SHALL be 1 and vic_ready_o SHALL be 0. acc_valid_i and vic_req_i SHALL be ignored, with no state change and no vic_valid_o.
REQ-027 From IDLE, flush_i=1 SHALL enter SWEEP with cnt=0 at the next edge. The access and query of that same cycle SHALL still be processed.
REQ-028 flush_i=1 during SWEEP SHALL restart cnt at 0.
REQ-029 Counter wrap SHALL NOT occur outside SWEEP; cnt SHALL be 0 in IDLE.

Reset
REQ-030 rst_ni=0 at an edge SHALL set FSM=SWEEP, cnt=0, busy_o=1, vic_ready_o=0, vic_valid_o=0 and vic_way_o=0.
REQ-031 State contents SHALL be cleared by the sweep, not by reset, so the array may map to RAM.
REQ-032 Reset asserted mid-sweep or mid-query SHALL restart the sweep and drop any pending vic_valid_o.
REQ-033 After reset deassertion, busy_o SHALL fall exactly NUM_SET cycles later.

Verification (NUM_WAY=4, NUM_SET=64)
REQ-034 Reset then wait: busy_o stays 1 for 64 cycles. A query of set 5 then returns vic_way_o=0001 one cycle later.
REQ-035 Touch sequence on set 5: touch 0001 -> victim 0100. Then touch 0100 -> victim 0010. Set 6 stays at victim 0001.
REQ-036 Same-cycle touch 0001 and query on set 3: vic_way_o=0001. A following query returns 0100.
REQ-037 Multi-hot touch 0011 on a fresh set -> victim 0100. Touch 0000 -> victim unchanged.
REQ-038 Flush mid-traffic: after touches, pulse flush_i. Accesses during the 64 busy cycles are ignored, vic_ready_o=0, and all sets return 0001 afterwards. A flush at sweep cycle 30 extends busy_o to 64 cycles from the restart.
REQ-039 Back-to-back queries on different sets each cycle: one vic_valid_o per query, in order, no gaps.
